// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded R/I/J instruction fields into 32-bit MIPS words,
// buffers them in a small FIFO and streams them out over valid/ready, keeping
// per-format counts of the words actually emitted.
module inst_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_kind,
  input  logic [5:0]               in_op,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [5:0]               in_funct,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              inst32,
  output logic [CW-1:0]            r_cnt,
  output logic [CW-1:0]            i_cnt,
  output logic [CW-1:0]            j_cnt,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] TAG_R = 2'b00;
  localparam logic [1:0] TAG_I = 2'b01;
  localparam logic [1:0] TAG_J = 2'b10;

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] word;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     last_q, last_d;
  logic [CW-1:0]   r_cnt_q, r_cnt_d;
  logic [CW-1:0]   i_cnt_q, i_cnt_d;
  logic [CW-1:0]   j_cnt_q, j_cnt_d;
  logic            err_q, err_d;

  logic [31:0]     enc_word;
  logic            enc_legal;
  logic            accept;
  logic            push;
  logic            pop;
  entry_t          head;

  // Format the incoming bundle and decide whether it is a legal instruction
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (in_kind)
      TAG_R: begin
        enc_word  = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
        enc_legal = 1'b1;
      end
      TAG_I: begin
        enc_word  = {in_op, in_rs, in_rt, in_imm};
        enc_legal = (in_op != 6'h00) && (in_op != 6'h02) && (in_op != 6'h03);
      end
      TAG_J: begin
        enc_word  = {in_op, in_target};
        enc_legal = (in_op == 6'h02) || (in_op == 6'h03);
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Handshake qualifiers; readiness depends only on occupancy
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  // Empty FIFO keeps presenting the last emitted word
  assign inst32 = out_valid ? head.word : last_q;
  assign r_cnt  = r_cnt_q;
  assign i_cnt  = i_cnt_q;
  assign j_cnt  = j_cnt_q;
  assign err    = err_q;
  assign level  = level_q;

  // Next-state for pointers, occupancy, counters and the sticky error
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    r_cnt_d  = r_cnt_q;
    i_cnt_d  = i_cnt_q;
    j_cnt_d  = j_cnt_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = head.word;
      case (head.tag)
        TAG_R:   r_cnt_d = r_cnt_q + CW'(1);
        TAG_I:   i_cnt_d = i_cnt_q + CW'(1);
        TAG_J:   j_cnt_d = j_cnt_q + CW'(1);
        default: r_cnt_d = r_cnt_q;
      endcase
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (accept && !enc_legal) err_d = 1'b1;
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
      r_cnt_q  <= '0;
      i_cnt_q  <= '0;
      j_cnt_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
      r_cnt_q  <= r_cnt_d;
      i_cnt_q  <= i_cnt_d;
      j_cnt_q  <= j_cnt_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage: encoded word plus its format tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{tag: in_kind, word: enc_word};
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: a driver pushes expected words computed
// from the field values, a negedge monitor compares every visible output.
module tb_inst_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int CMOD  = 1 << CW;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_kind;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid, out_ready;
  logic [31:0] inst32;
  logic [CW-1:0] r_cnt, i_cnt, j_cnt;
  logic        err;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .inst32(inst32),
    .r_cnt(r_cnt), .i_cnt(i_cnt), .j_cnt(j_cnt), .err(err), .level(level)
  );

  typedef struct {
    logic [31:0] word;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt[3];
  bit          exp_err;
  logic [31:0] last_word;
  int          rdy_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: which bundles are real instructions
  function automatic bit model_legal(input int kind, input int op);
    case (kind)
      0:       return 1'b1;
      1:       return !(op == 0 || op == 2 || op == 3);
      2:       return (op == 2 || op == 3);
      default: return 1'b0;
    endcase
  endfunction

  // Reference: MIPS field placement as weighted sums
  function automatic logic [31:0] model_word(input int kind, input longint op, input longint rs,
                                             input longint rt, input longint rd, input longint sh,
                                             input longint fn, input longint imm, input longint tg);
    longint v;
    case (kind)
      0:       v = rs * (64'd1 << 21) + rt * (64'd1 << 16) + rd * 2048 + sh * 64 + fn;
      1:       v = op * (64'd1 << 26) + rs * (64'd1 << 21) + rt * (64'd1 << 16) + imm;
      default: v = op * (64'd1 << 26) + tg;
    endcase
    return 32'(v);
  endfunction

  // Present one bundle and hold it until accepted; leaves in_valid high
  task automatic send(input int k, input int op, input int rs, input int rt, input int rd,
                      input int sh, input int fn, input int imm, input int tg);
    bit acc;
    int t;
    in_kind   = 2'(k);
    in_op     = 6'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_funct  = 6'(fn);
    in_imm    = 16'(imm);
    in_target = 26'(tg);
    in_valid  = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (acc) begin
      if (model_legal(k, op)) begin
        exp_t e;
        e.word = model_word(k, op, rs, rt, rd, sh, fn, imm, tg);
        e.tag  = k;
        sb.push_back(e);
      end else begin
        exp_err = 1'b1;
      end
    end else begin
      n_bad++;
      $display("FAIL accept_timeout: got no handshake expected one within 200 cycles");
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t;
    in_valid = 1'b0;
    rdy_pct  = 100;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 200) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Asserted mid-cycle; outputs must clear before the next edge
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_inst32", inst32, 0);
    check("rst_r_cnt", r_cnt, 0);
    check("rst_i_cnt", i_cnt, 0);
    check("rst_j_cnt", j_cnt, 0);
    check("rst_err", err, 0);
    sb.delete();
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    exp_err   = 1'b0;
    last_word = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Downstream acceptance pattern
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: compare outputs against the scoreboard, pop on emit
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        int          sz;
        logic [31:0] want;
        exp_t        e;
        sz   = sb.size();
        want = (sz != 0) ? sb[0].word : last_word;
        check("level", level, sz);
        check("in_ready", in_ready, sz != DEPTH);
        check("out_valid", out_valid, sz != 0);
        check("inst32", inst32, want);
        check("r_cnt", r_cnt, cnt[0] % CMOD);
        check("i_cnt", i_cnt, cnt[1] % CMOD);
        check("j_cnt", j_cnt, cnt[2] % CMOD);
        check("err", err, exp_err);
        if (sz != 0 && out_ready) begin
          e = sb.pop_front();
          last_word = e.word;
          cnt[e.tag]++;
        end
      end
    end
  end

  initial begin
    in_valid = 1'b0;
    in_kind = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_funct = '0; in_imm = '0; in_target = '0;
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    exp_err = 1'b0;
    last_word = '0;
    rst = 1'b1;
    #2;
    check("por_level", level, 0);
    check("por_out_valid", out_valid, 0);
    check("por_inst32", inst32, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // R encode
    rdy_pct = 100;
    @(posedge clk); #1;
    send(0, 6'h3f, 1, 2, 3, 0, 6'h20, 0, 0);
    idle_cycles(3);

    // I and J encode
    send(1, 6'h08, 1, 4, 0, 0, 0, 16'h0005, 0);
    send(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h0000010);
    idle_cycles(3);

    // Illegal bundles are consumed and dropped
    send(3, 6'h00, 7, 7, 7, 7, 7, 16'hffff, 26'h3ffffff);
    send(2, 6'h08, 0, 0, 0, 0, 0, 0, 26'h0000123);
    send(1, 6'h02, 3, 3, 0, 0, 0, 16'h1234, 0);
    idle_cycles(3);

    // Backpressure: fill the FIFO, fifth bundle waits for the first pop
    rdy_pct = 0;
    idle_cycles(2);
    fork
      begin
        repeat (9) @(posedge clk);
        rdy_pct = 100;
      end
    join_none
    for (int n = 0; n < 5; n++) send(1, 6'h08 + n, n, n + 1, 0, 0, 0, 16'h0100 + n, 0);
    wait_drain();

    // Continuous push/pop with pointer and counter wrap
    for (int n = 0; n < 10; n++) send(0, 0, n, n + 2, n + 4, n, 6'h21, 0, 0);
    wait_drain();

    // Reset with data in flight
    rdy_pct = 0;
    idle_cycles(2);
    for (int n = 0; n < 3; n++) send(0, 0, 9, n, 1, 0, 6'h22, 0, 0);
    idle_cycles(1);
    check("pre_rst_level", level, 3);
    do_reset();
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rdy_pct = 60;
    for (int n = 0; n < 300; n++) begin
      int k, op;
      k = $urandom_range(0, 3);
      case (k)
        1:       op = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63);
        2:       op = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 63) : $urandom_range(2, 3);
        default: op = $urandom_range(0, 63);
      endcase
      send(k, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
           $urandom_range(0, 32'h3ffffff));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    wait_drain();
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
